lsu_addrchk_arb: RTL and testbench
==================================

// Module: lsu_addrchk_arb
// PURPOSE
//  Shares the single DC1 address-check / DCCM access port between the core LSU pipe and the DMA slave.
//  Each cycle it grants one requester and drives the checker with start/end address and size strobes.
//  It registers the checker's fault verdict back to the granted requester one cycle later.
//  Core has default priority; a starvation counter and a DMA burst limit bound the wait on either side.
// PARAMETERS
//  DMA_MAX_WAIT   15  cycles a pending DMA request may be refused before it gets priority
//  DMA_BURST_MAX  4   max consecutive DMA grants while core is requesting; then core gets one grant
//  CNT_W          $clog2(DMA_MAX_WAIT+1)  width of the wait counter (derived, do not override)
// PORTS
//  clk              in   1   core clock
//  rst_l            in   1   reset, synchronous, active-low
//  lsu_freeze_dc3   in   1   pipe freeze; no new grants, all state held
//  core_req_valid   in   1   core access request
//  core_addr        in   32  core start address
//  core_size        in   2   0=byte 1=half 2=word (3 illegal -> treated as word)
//  core_req_ready   out  1   core request granted this cycle
//  dma_req_valid    in   1   DMA access request
//  dma_addr         in   32  DMA start address
//  dma_size         in   2   as core_size
//  dma_req_ready    out  1   DMA request granted this cycle
//  chk_valid        out  1   checker packet valid (= any grant)
//  chk_start_addr   out  32  start address to checker
//  chk_end_addr     out  32  start + nbytes-1, modulo 2^32
//  chk_by/half/word out  1   one-hot size strobes
//  chk_dma          out  1   packet is DMA
//  access_fault     in   1   checker verdict, combinational, same cycle as chk_valid
//  misaligned_fault in   1   checker verdict, combinational
//  rsp_core_valid   out  1   registered verdict for core grant of previous cycle
//  rsp_dma_valid    out  1   registered verdict for DMA grant of previous cycle
//  rsp_access_fault out  1   registered access_fault (forced 0 for DMA responses)
//  rsp_misaligned   out  1   registered misaligned_fault (forced 0 for DMA responses)
// BEHAVIOUR
//  Reset
//   - All outputs 0.
//   - FSM = CORE_PRI; wait_cnt = 0; burst_cnt = 0.
//  Handshake
//   - Requesters hold valid, addr and size stable until ready.
//   - A grant is combinational: ready in the same cycle as valid.
//   - At most one ready per cycle. Never ready while lsu_freeze_dc3 = 1.
//  FSM CORE_PRI
//   - Core granted if valid; otherwise DMA granted if valid.
//   - Exception: when burst_cnt == DMA_BURST_MAX is not the condition here; see below.
//   - Go to DMA_PRI when wait_cnt == DMA_MAX_WAIT and DMA is still pending.
//  FSM DMA_PRI
//   - DMA granted if valid, unless burst_cnt == DMA_BURST_MAX and core is valid; then core is granted.
//   - Return to CORE_PRI when dma_req_valid = 0.
//  Counters
//   - wait_cnt: +1 each unfrozen cycle with dma_req_valid & ~dma_req_ready; saturates at DMA_MAX_WAIT.
//   - wait_cnt clears on a DMA grant or when dma_req_valid = 0.
//   - burst_cnt: +1 on a DMA grant while core_req_valid = 1; saturates.
//   - burst_cnt clears on a core grant or when core_req_valid = 0.
//  Checker outputs
//   - Muxed from the granted requester; all zero when there is no grant.
//   - chk_end_addr wraps: 0xFFFF_FFFF word -> 0x0000_0002.
//  Response
//   - Fault inputs and the owner are captured one cycle after the grant: rsp_*_valid pulses for 1 cycle.
//   - When lsu_freeze_dc3 = 1, response registers hold their value and do not re-pulse.
//  Reset mid-operation
//   - Pending responses are dropped; both counters clear.
// STRUCTURE
//  - swerv_types gains the size typedef lsu_size_e (BYTE/HALF/WORD) and the FSM enum arb_state_e (CORE_PRI/DMA_PRI).
//  - One sub-module, lsu_arb_satcnt: a saturating counter with inc/clr/hold.
//    Instantiate it twice, for wait_cnt and burst_cnt.
//  - All flops use rvdff with synchronous reset on rst_l.
// TESTING
//  1. Core word 0xF004_0000 only -> core_req_ready same cycle.
//     chk_end_addr = 0xF004_0003, chk_word = 1; rsp_core_valid next cycle.
//  2. Core and DMA both valid, core continuous -> DMA refused 15 cycles.
//     DMA granted on cycle 16; core_req_ready = 0 that cycle.
//  3. In DMA_PRI, DMA and core both held valid -> 4 DMA grants, then 1 core grant, then DMA again.
//  4. access_fault = 1 on a core grant -> rsp_access_fault = 1 with rsp_core_valid the next cycle.
//     For a DMA grant, rsp_access_fault = 0.
//  5. Core half at 0xFFFF_FFFF -> chk_end_addr = 0x0000_0000, chk_half = 1, no X.
//  6. lsu_freeze_dc3 held 3 cycles with both requesting -> no ready, counters frozen.
//     rst_l = 0 during the freeze -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/lsu_addrchk_arb_pkg.sv
// Shared types for the LSU/DMA address-check arbiter: access size encoding,
// arbiter state and the size-to-last-byte-offset helper.
package lsu_addrchk_arb_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [0:0] {
    CORE_PRI = 1'b0,
    DMA_PRI  = 1'b1
  } arb_state_e;

  // Offset of the last byte touched; the illegal encoding 3 behaves as a word.
  function automatic logic [1:0] size_last_off(input logic [1:0] size);
    case (size)
      BYTE:    size_last_off = 2'd0;
      HALF:    size_last_off = 2'd1;
      default: size_last_off = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_arb_satcnt.sv
// Saturating up-counter with hold > clear > increment priority and
// synchronous active-low reset.
module lsu_arb_satcnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         hold,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (!hold) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != W'(MAX))) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_addrchk_arb.sv
// Arbitrates the single DC1 address-check port between the core LSU pipe and
// the DMA slave, and returns the registered checker verdict to the winner.
module lsu_addrchk_arb
  import lsu_addrchk_arb_pkg::*;
#(
  parameter int DMA_MAX_WAIT  = 15,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        lsu_freeze_dc3,
  input  logic        core_req_valid,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_size,
  output logic        core_req_ready,
  input  logic        dma_req_valid,
  input  logic [31:0] dma_addr,
  input  logic [1:0]  dma_size,
  output logic        dma_req_ready,
  output logic        chk_valid,
  output logic [31:0] chk_start_addr,
  output logic [31:0] chk_end_addr,
  output logic        chk_by,
  output logic        chk_half,
  output logic        chk_word,
  output logic        chk_dma,
  input  logic        access_fault,
  input  logic        misaligned_fault,
  output logic        rsp_core_valid,
  output logic        rsp_dma_valid,
  output logic        rsp_access_fault,
  output logic        rsp_misaligned,
  output arb_state_e  dbg_state,
  output logic [$clog2(DMA_MAX_WAIT+1)-1:0]  dbg_wait_cnt,
  output logic [$clog2(DMA_BURST_MAX+1)-1:0] dbg_burst_cnt
);

  localparam int CNT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam int BST_W = $clog2(DMA_BURST_MAX + 1);

  arb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [BST_W-1:0] burst_cnt;
  logic             can_grant;
  logic             burst_full;
  logic             core_gnt;
  logic             dma_gnt;
  logic             dma_starved;
  logic [31:0]      sel_addr;
  logic [1:0]       sel_size;

  // Handshake: a requester holds valid/addr/size until ready; ready is a
  // same-cycle combinational grant, at most one per cycle, never while frozen
  // or in reset.
  assign can_grant  = rst_l & ~lsu_freeze_dc3;
  assign burst_full = (burst_cnt == BST_W'(DMA_BURST_MAX));

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (can_grant) begin
      if (state == DMA_PRI) begin
        dma_gnt  = dma_req_valid & ~(burst_full & core_req_valid);
        core_gnt = core_req_valid & ~dma_gnt;
      end else begin
        core_gnt = core_req_valid;
        dma_gnt  = dma_req_valid & ~core_req_valid;
      end
    end
  end

  // Switch as this refusal brings the wait to its limit, so the next cycle wins.
  assign dma_starved = dma_req_valid & ~dma_gnt &
                       (wait_cnt >= CNT_W'(DMA_MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= CORE_PRI;
    end else if (!lsu_freeze_dc3) begin
      case (state)
        CORE_PRI: if (dma_starved)    state <= DMA_PRI;
        DMA_PRI:  if (!dma_req_valid) state <= CORE_PRI;
        default:                      state <= CORE_PRI;
      endcase
    end
  end

  lsu_arb_satcnt #(.W(CNT_W), .MAX(DMA_MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .hold  (lsu_freeze_dc3),
    .clr   (dma_gnt | ~dma_req_valid),
    .inc   (dma_req_valid & ~dma_gnt),
    .cnt   (wait_cnt)
  );

  lsu_arb_satcnt #(.W(BST_W), .MAX(DMA_BURST_MAX)) u_burst_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .hold  (lsu_freeze_dc3),
    .clr   (core_gnt | ~core_req_valid),
    .inc   (dma_gnt & core_req_valid),
    .cnt   (burst_cnt)
  );

  always_comb begin
    sel_addr = 32'h0;
    sel_size = 2'd0;
    if (core_gnt) begin
      sel_addr = core_addr;
      sel_size = core_size;
    end else if (dma_gnt) begin
      sel_addr = dma_addr;
      sel_size = dma_size;
    end
  end

  assign core_req_ready = core_gnt;
  assign dma_req_ready  = dma_gnt;
  assign chk_valid      = core_gnt | dma_gnt;
  assign chk_dma        = dma_gnt;
  assign chk_start_addr = sel_addr;
  assign chk_end_addr   = chk_valid ? (sel_addr + 32'(size_last_off(sel_size))) : 32'h0;
  assign chk_by         = chk_valid & (sel_size == BYTE);
  assign chk_half       = chk_valid & (sel_size == HALF);
  assign chk_word       = chk_valid & (sel_size != BYTE) & (sel_size != HALF);

  // Frozen cycles keep the last verdict but never re-raise a valid.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rsp_core_valid   <= 1'b0;
      rsp_dma_valid    <= 1'b0;
      rsp_access_fault <= 1'b0;
      rsp_misaligned   <= 1'b0;
    end else if (lsu_freeze_dc3) begin
      rsp_core_valid   <= 1'b0;
      rsp_dma_valid    <= 1'b0;
    end else begin
      rsp_core_valid   <= core_gnt;
      rsp_dma_valid    <= dma_gnt;
      rsp_access_fault <= core_gnt & access_fault;
      rsp_misaligned   <= core_gnt & misaligned_fault;
    end
  end

  assign dbg_state     = state;
  assign dbg_wait_cnt  = wait_cnt;
  assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_lsu_addrchk_arb.sv
// Directed bench for lsu_addrchk_arb: sizes/wrap, fault return, starvation,
// DMA burst limit, freeze and reset during freeze.
module tb_lsu_addrchk_arb;
  import lsu_addrchk_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        lsu_freeze_dc3;
  logic        core_req_valid;
  logic [31:0] core_addr;
  logic [1:0]  core_size;
  logic        core_req_ready;
  logic        dma_req_valid;
  logic [31:0] dma_addr;
  logic [1:0]  dma_size;
  logic        dma_req_ready;
  logic        chk_valid;
  logic [31:0] chk_start_addr;
  logic [31:0] chk_end_addr;
  logic        chk_by;
  logic        chk_half;
  logic        chk_word;
  logic        chk_dma;
  logic        access_fault;
  logic        misaligned_fault;
  logic        rsp_core_valid;
  logic        rsp_dma_valid;
  logic        rsp_access_fault;
  logic        rsp_misaligned;
  arb_state_e  dbg_state;
  logic [3:0]  dbg_wait_cnt;
  logic [2:0]  dbg_burst_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_addrchk_arb dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .lsu_freeze_dc3   (lsu_freeze_dc3),
    .core_req_valid   (core_req_valid),
    .core_addr        (core_addr),
    .core_size        (core_size),
    .core_req_ready   (core_req_ready),
    .dma_req_valid    (dma_req_valid),
    .dma_addr         (dma_addr),
    .dma_size         (dma_size),
    .dma_req_ready    (dma_req_ready),
    .chk_valid        (chk_valid),
    .chk_start_addr   (chk_start_addr),
    .chk_end_addr     (chk_end_addr),
    .chk_by           (chk_by),
    .chk_half         (chk_half),
    .chk_word         (chk_word),
    .chk_dma          (chk_dma),
    .access_fault     (access_fault),
    .misaligned_fault (misaligned_fault),
    .rsp_core_valid   (rsp_core_valid),
    .rsp_dma_valid    (rsp_dma_valid),
    .rsp_access_fault (rsp_access_fault),
    .rsp_misaligned   (rsp_misaligned),
    .dbg_state        (dbg_state),
    .dbg_wait_cnt     (dbg_wait_cnt),
    .dbg_burst_cnt    (dbg_burst_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  initial begin
    logic       exp_dma;
    logic [2:0] exp_burst [6];
    exp_burst = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    rst_l = 1'b0; lsu_freeze_dc3 = 1'b0;
    core_req_valid = 1'b0; core_addr = 32'h0; core_size = 2'd0;
    dma_req_valid = 1'b0; dma_addr = 32'h0; dma_size = 2'd0;
    access_fault = 1'b0; misaligned_fault = 1'b0;

    // Reset with a core request already asserted
    step();
    core_req_valid = 1'b1; core_addr = 32'hF004_0000; core_size = 2'd2;
    settle();
    chk1("rst_core_ready", core_req_ready, 1'b0);
    chk1("rst_chk_valid", chk_valid, 1'b0);
    chk32("rst_end_addr", chk_end_addr, 32'h0);
    step(); settle();
    chk1("rst_rsp_core", rsp_core_valid, 1'b0);
    chk1("rst_state", dbg_state, CORE_PRI);
    chk32("rst_wait", 32'(dbg_wait_cnt), 32'h0);
    chk32("rst_burst", 32'(dbg_burst_cnt), 32'h0);

    // Core word, alone
    step(); rst_l = 1'b1; settle();
    chk1("t1_core_ready", core_req_ready, 1'b1);
    chk1("t1_dma_ready", dma_req_ready, 1'b0);
    chk1("t1_chk_valid", chk_valid, 1'b1);
    chk32("t1_start", chk_start_addr, 32'hF004_0000);
    chk32("t1_end", chk_end_addr, 32'hF004_0003);
    chk1("t1_word", chk_word, 1'b1);
    chk1("t1_half", chk_half, 1'b0);
    chk1("t1_dma", chk_dma, 1'b0);
    step(); core_req_valid = 1'b0; settle();
    chk1("t1_rsp_core", rsp_core_valid, 1'b1);
    chk1("t1_rsp_dma", rsp_dma_valid, 1'b0);
    chk1("t1_idle_valid", chk_valid, 1'b0);
    chk32("t1_idle_start", chk_start_addr, 32'h0);
    step(); settle();
    chk1("t1_rsp_pulse", rsp_core_valid, 1'b0);

    // Sizes and wrap-around
    step(); core_req_valid = 1'b1; core_addr = 32'hFFFF_FFFF; core_size = 2'd1; settle();
    chk32("t5_half_wrap_end", chk_end_addr, 32'h0000_0000);
    chk1("t5_half", chk_half, 1'b1);
    chk1("t5_half_word", chk_word, 1'b0);
    chk1("t5_half_by", chk_by, 1'b0);
    step(); core_size = 2'd2; settle();
    chk32("t5_word_wrap_end", chk_end_addr, 32'h0000_0002);
    chk1("t5_word", chk_word, 1'b1);
    step(); core_addr = 32'h1000_0100; core_size = 2'd3; settle();
    chk32("t5_illegal_end", chk_end_addr, 32'h1000_0103);
    chk1("t5_illegal_word", chk_word, 1'b1);
    step(); core_addr = 32'h0000_0010; core_size = 2'd0; settle();
    chk32("t5_byte_end", chk_end_addr, 32'h0000_0010);
    chk1("t5_byte", chk_by, 1'b1);

    // Fault return: core keeps the verdict, DMA has it forced low
    step(); core_addr = 32'h2000_0001; core_size = 2'd1;
    access_fault = 1'b1; misaligned_fault = 1'b1; settle();
    chk1("t4_core_ready", core_req_ready, 1'b1);
    step(); core_req_valid = 1'b0;
    dma_req_valid = 1'b1; dma_addr = 32'hF004_1000; dma_size = 2'd2; settle();
    chk1("t4_rsp_core", rsp_core_valid, 1'b1);
    chk1("t4_rsp_access", rsp_access_fault, 1'b1);
    chk1("t4_rsp_misal", rsp_misaligned, 1'b1);
    chk1("t4_dma_ready", dma_req_ready, 1'b1);
    chk1("t4_chk_dma", chk_dma, 1'b1);
    chk32("t4_dma_start", chk_start_addr, 32'hF004_1000);
    chk32("t4_dma_end", chk_end_addr, 32'hF004_1003);
    step(); dma_req_valid = 1'b0; access_fault = 1'b0; misaligned_fault = 1'b0; settle();
    chk1("t4_rsp_dma", rsp_dma_valid, 1'b1);
    chk1("t4_rsp_core_low", rsp_core_valid, 1'b0);
    chk1("t4_dma_access", rsp_access_fault, 1'b0);
    chk1("t4_dma_misal", rsp_misaligned, 1'b0);
    step(); settle();

    // Starvation: both requesting, DMA refused 15 times
    for (int i = 1; i <= 15; i++) begin
      step();
      core_req_valid = 1'b1; core_addr = 32'h3000_0000; core_size = 2'd2;
      dma_req_valid = 1'b1; dma_addr = 32'h4000_0000; dma_size = 2'd2;
      settle();
      chk1("t2_core_ready", core_req_ready, 1'b1);
      chk1("t2_dma_refused", dma_req_ready, 1'b0);
      chk32("t2_wait_cnt", 32'(dbg_wait_cnt), 32'(i - 1));
    end

    // Cycle 16 onward: DMA wins, burst of 4, one core slot, DMA again
    for (int k = 0; k < 6; k++) begin
      step(); settle();
      exp_dma = (k != 4);
      chk1("t3_dma_ready", dma_req_ready, exp_dma);
      chk1("t3_core_ready", core_req_ready, ~exp_dma);
      chk1("t3_chk_dma", chk_dma, exp_dma);
      chk1("t3_state", dbg_state, DMA_PRI);
      chk32("t3_burst", 32'(dbg_burst_cnt), 32'(exp_burst[k]));
    end

    // Freeze for 3 cycles with both requesting
    for (int j = 0; j < 3; j++) begin
      step(); lsu_freeze_dc3 = 1'b1; settle();
      chk1("t6_core_ready", core_req_ready, 1'b0);
      chk1("t6_dma_ready", dma_req_ready, 1'b0);
      chk1("t6_chk_valid", chk_valid, 1'b0);
      chk32("t6_burst_held", 32'(dbg_burst_cnt), 32'h1);
      chk1("t6_state_held", dbg_state, DMA_PRI);
      chk1("t6_rsp_dma", rsp_dma_valid, (j == 0));
    end

    // Reset during the freeze
    step(); rst_l = 1'b0; settle();
    chk1("t6_rst_ready", dma_req_ready, 1'b0);
    step(); settle();
    chk1("t6_rst_state", dbg_state, CORE_PRI);
    chk32("t6_rst_burst", 32'(dbg_burst_cnt), 32'h0);
    chk32("t6_rst_wait", 32'(dbg_wait_cnt), 32'h0);
    chk1("t6_rst_rsp_dma", rsp_dma_valid, 1'b0);
    chk1("t6_rst_rsp_core", rsp_core_valid, 1'b0);
    chk1("t6_rst_chk_valid", chk_valid, 1'b0);
    step(); rst_l = 1'b1; lsu_freeze_dc3 = 1'b0; settle();
    chk1("t6_post_core", core_req_ready, 1'b1);
    chk1("t6_post_dma", dma_req_ready, 1'b0);
    step(); core_req_valid = 1'b0; dma_req_valid = 1'b0; settle();
    chk1("t6_post_rsp", rsp_core_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
